alu_issue: RTL and testbench

//  Execute-issue stage directly upstream of the ALU. Registers one decoded op per cycle,

---
 rtl/alu_issue.sv | 134 +++++++++++++
 tb/tb_alu_issue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Execute-issue stage in front of a single-cycle-latency ALU: E drives the ALU, W presents the
// result one cycle later to writeback, with operand forwarding, hold/flush and div-by-zero reporting.
module alu_issue #(
    parameter int              XLEN   = 32,
    parameter int              OPW    = 5,
    parameter logic [OPW-1:0]  OP_ADD = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_op,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic            in_wen,
    input  logic            hold,
    input  logic            flush,
    output logic [OPW-1:0]  alu_op,
    output logic [XLEN-1:0] alu_r1,
    output logic [XLEN-1:0] alu_r2,
    input  logic [XLEN-1:0] alu_res,
    input  logic            alu_illegal,
    output logic            wb_valid,
    output logic            wb_wen,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            exc_valid
);

    logic                  e_valid_q, e_wen_q;
    logic [OPW-1:0]        e_op_q;
    logic [4:0]            e_rd_q;
    logic [1:0][4:0]       e_src_q;
    logic [1:0][XLEN-1:0]  e_opnd_q;
    logic [1:0]            e_res_q;

    logic                  w_valid_q, w_wen_q, w_exc_q, w_fresh_q;
    logic [4:0]            w_rd_q;
    logic [XLEN-1:0]       w_data_q;
    logic                  hold_q;

    logic                  w_fwd_ok, first_hold;
    logic [1:0][4:0]       in_src;
    logic [1:0][XLEN-1:0]  in_val, e_cur, cap;
    logic [1:0]            in_fwd, e_fwd;

    // W's value: live ALU result in its first cycle, captured copy afterwards
    assign wb_data    = w_fresh_q ? alu_res : w_data_q;
    assign w_fwd_ok   = w_valid_q & w_wen_q & ~w_exc_q;
    assign first_hold = hold & ~hold_q;

    assign in_src[0] = in_rs1;
    assign in_src[1] = in_rs2;
    assign in_val[0] = in_rs1_val;
    assign in_val[1] = in_rs2_val;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            assign in_fwd[gi] = w_fwd_ok && (w_rd_q == in_src[gi]) && (in_src[gi] != 5'd0);
            assign e_fwd[gi]  = w_fwd_ok && (w_rd_q == e_src_q[gi]) && (e_src_q[gi] != 5'd0)
                                && !e_res_q[gi];
            assign e_cur[gi]  = e_fwd[gi] ? wb_data : e_opnd_q[gi];
        end
    endgenerate

    assign cap[0] = in_fwd[0] ? wb_data : in_val[0];
    assign cap[1] = in_use_imm ? in_imm : (in_fwd[1] ? wb_data : in_val[1]);

    assign in_ready  = ~hold;
    assign alu_op    = e_valid_q ? e_op_q   : OP_ADD;
    assign alu_r1    = e_valid_q ? e_cur[0] : '0;
    assign alu_r2    = e_valid_q ? e_cur[1] : '0;

    // A W op sees exactly one non-held cycle (its last), so write/exception fire once there
    assign wb_valid  = w_valid_q;
    assign wb_rd     = w_rd_q;
    assign wb_wen    = w_valid_q & w_wen_q & ~w_exc_q & (w_rd_q != 5'd0) & ~hold;
    assign exc_valid = w_valid_q & w_exc_q & ~hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid_q <= 1'b0;
            e_wen_q   <= 1'b0;
            e_op_q    <= OP_ADD;
            e_rd_q    <= '0;
            e_src_q   <= '0;
            e_opnd_q  <= '0;
            e_res_q   <= '0;
            w_valid_q <= 1'b0;
            w_wen_q   <= 1'b0;
            w_exc_q   <= 1'b0;
            w_fresh_q <= 1'b0;
            w_rd_q    <= '0;
            w_data_q  <= '0;
            hold_q    <= 1'b0;
        end else begin
            hold_q <= hold;
            if (w_fresh_q) begin
                w_data_q <= alu_res;
            end
            if (hold) begin
                w_fresh_q <= 1'b0;
                if (flush) begin
                    e_valid_q <= 1'b0;
                end
                // alu_res stops belonging to W once the ALU recomputes E, so pin E's operands
                if (first_hold) begin
                    e_opnd_q <= e_cur;
                    e_res_q  <= 2'b11;
                end
            end else begin
                e_valid_q <= in_valid & ~flush;
                e_op_q    <= in_op;
                e_rd_q    <= in_rd;
                e_wen_q   <= in_wen;
                e_src_q   <= in_src;
                e_opnd_q  <= cap;
                e_res_q   <= {in_use_imm, 1'b0};
                w_valid_q <= e_valid_q & ~flush;
                w_rd_q    <= e_rd_q;
                w_wen_q   <= e_wen_q;
                w_exc_q   <= e_valid_q & alu_illegal;
                w_fresh_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a small one-cycle-latency ALU model, a table of isolated ops,
// then directed sequences for forwarding, hold, flush, exceptions, x0 and reset.
module tb_alu_issue;

    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, DIV = 5'd2, REM = 5'd3;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_use_imm, in_wen, hold, flush;
    logic [4:0]  in_op, in_rs1, in_rs2, in_rd;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  alu_op;
    logic [31:0] alu_r1, alu_r2, alu_res;
    logic        alu_illegal;
    logic        wb_valid, wb_wen, exc_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int tests = 0;
    int fails = 0;
    logic [4:0]  log_rd[$];
    logic [31:0] log_data[$];
    int exc_cnt = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rs1_val(in_rs1_val),
        .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_use_imm(in_use_imm), .in_wen(in_wen),
        .hold(hold), .flush(flush), .alu_op(alu_op), .alu_r1(alu_r1), .alu_r2(alu_r2),
        .alu_res(alu_res), .alu_illegal(alu_illegal), .wb_valid(wb_valid), .wb_wen(wb_wen),
        .wb_rd(wb_rd), .wb_data(wb_data), .exc_valid(exc_valid)
    );

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            SUB:     return a - b;
            DIV:     return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:     return (b == 0) ? a : a % b;
            default: return a + b;
        endcase
    endfunction

    assign alu_illegal = ((alu_op == DIV) || (alu_op == REM)) && (alu_r2 == 32'd0);
    always_ff @(posedge clk) begin
        if (rst) alu_res <= '0;
        else     alu_res <= alu_f(alu_op, alu_r1, alu_r2);
    end

    always @(negedge clk) begin
        if (wb_wen === 1'b1) begin
            log_rd.push_back(wb_rd);
            log_data.push_back(wb_data);
            $display("[TB] write x%0d <= %0h", wb_rd, wb_data);
        end
        if (exc_valid === 1'b1) begin
            exc_cnt++;
            $display("[TB] exception pulse");
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic offer(input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] imm, input logic ui, input logic wen);
        in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_val = v1; in_rs2_val = v2; in_imm = imm; in_use_imm = ui; in_wen = wen;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_op = ADD; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_rs1_val = '0; in_rs2_val = '0; in_imm = '0; in_use_imm = 1'b0; in_wen = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  op, rs1, rs2, rd;
        logic [31:0] v1, v2, imm;
        logic        ui, wen;
        logic [31:0] exp_r2;
        logic        exp_wen, exp_exc;
        logic [31:0] exp_data;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                                input logic [31:0] imm, input logic ui, input logic wen,
                                input logic [31:0] exp_r2, input logic exp_wen, input logic exp_exc,
                                input logic [31:0] exp_data);
        vec_t v;
        v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.v1 = v1; v.v2 = v2; v.imm = imm;
        v.ui = ui; v.wen = wen; v.exp_r2 = exp_r2; v.exp_wen = exp_wen; v.exp_exc = exp_exc;
        v.exp_data = exp_data;
        return v;
    endfunction

    vec_t vecs[9];
    int n0, e0;

    initial begin
        vecs[0] = mk(ADD, 2, 3, 1, 5, 7, 0, 0, 1, 7, 1, 0, 12);
        vecs[1] = mk(SUB, 9, 10, 4, 20, 99, 2, 1, 1, 2, 1, 0, 18);
        vecs[2] = mk(DIV, 3, 4, 5, 20, 0, 0, 0, 1, 0, 0, 1, 0);
        vecs[3] = mk(ADD, 1, 2, 0, 3, 4, 0, 0, 1, 4, 0, 0, 7);
        vecs[4] = mk(ADD, 1, 2, 6, 3, 4, 0, 0, 0, 4, 0, 0, 7);
        vecs[5] = mk(REM, 1, 2, 7, 17, 5, 0, 0, 1, 5, 1, 0, 2);
        vecs[6] = mk(DIV, 1, 2, 8, 20, 0, 4, 1, 1, 4, 1, 0, 5);
        vecs[7] = mk(REM, 1, 2, 9, 17, 0, 0, 0, 1, 0, 0, 1, 0);
        vecs[8] = mk(SUB, 1, 2, 31, 3, 5, 0, 0, 1, 5, 1, 0, 32'hFFFF_FFFE);

        rst = 1'b1; hold = 1'b0; flush = 1'b0; idle();
        cyc(); cyc(); settle();
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_wen", wb_wen, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_exc", exc_valid, 0);
        chk("rst_alu_op", alu_op, ADD);
        chk("rst_alu_r1", alu_r1, 0);
        chk("rst_alu_r2", alu_r2, 0);
        chk("rst_in_ready", in_ready, 1);
        cyc(); rst = 1'b0;

        // Isolated ops, one at a time through E and W
        for (int i = 0; i < 9; i++) begin
            n0 = log_rd.size(); e0 = exc_cnt;
            cyc(); offer(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].v1,
                         vecs[i].v2, vecs[i].imm, vecs[i].ui, vecs[i].wen);
            cyc(); idle(); settle();
            chk($sformatf("v%0d_alu_op", i), alu_op, vecs[i].op);
            chk($sformatf("v%0d_alu_r1", i), alu_r1, vecs[i].v1);
            chk($sformatf("v%0d_alu_r2", i), alu_r2, vecs[i].exp_r2);
            cyc(); settle();
            chk($sformatf("v%0d_wb_valid", i), wb_valid, 1);
            chk($sformatf("v%0d_wb_wen", i), wb_wen, vecs[i].exp_wen);
            chk($sformatf("v%0d_wb_rd", i), wb_rd, vecs[i].rd);
            chk($sformatf("v%0d_exc", i), exc_valid, vecs[i].exp_exc);
            if (!vecs[i].exp_exc) chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].exp_data);
            cyc(); settle();
            chk($sformatf("v%0d_drained", i), wb_valid, 0);
            chk($sformatf("v%0d_writes", i), log_rd.size() - n0, vecs[i].exp_wen);
            chk($sformatf("v%0d_exc_count", i), exc_cnt - e0, vecs[i].exp_exc);
        end

        // Back-to-back RAW: SUB x4, x1, 2 right behind ADD x1 = 5 + 7
        n0 = log_rd.size();
        cyc(); offer(ADD, 2, 3, 1, 5, 7, 0, 0, 1);
        cyc(); offer(SUB, 1, 0, 4, 0, 0, 2, 1, 1);
        cyc(); idle(); settle();
        chk("raw_fwd_r1", alu_r1, 12);
        chk("raw_r2_imm", alu_r2, 2);
        chk("raw_w1_data", wb_data, 12);
        chk("raw_w1_wen", wb_wen, 1);
        cyc(); settle();
        chk("raw_w2_rd", wb_rd, 4);
        chk("raw_w2_data", wb_data, 10);
        cyc(); settle();
        chk("raw_writes", log_rd.size() - n0, 2);
        chk("raw_first_data", log_data[n0], 12);
        chk("raw_second_data", log_data[n0+1], 10);

        // x1 = x1 + 1 three times, hold for three cycles with op2 in W and op3 in E
        n0 = log_rd.size();
        cyc(); offer(ADD, 1, 0, 1, 0, 0, 1, 1, 1);
        cyc(); offer(ADD, 1, 0, 1, 0, 0, 1, 1, 1);
        cyc(); offer(ADD, 1, 0, 1, 0, 0, 1, 1, 1); settle();
        chk("hold_fwd1", alu_r1, 1);
        cyc(); idle(); hold = 1'b1; settle();
        chk("hold_in_ready", in_ready, 0);
        chk("hold_c1_wen", wb_wen, 0);
        chk("hold_c1_data", wb_data, 2);
        chk("hold_c1_r1", alu_r1, 2);
        cyc(); settle();
        chk("hold_c2_valid", wb_valid, 1);
        chk("hold_c2_wen", wb_wen, 0);
        chk("hold_c2_data", wb_data, 2);
        chk("hold_c2_r1", alu_r1, 2);
        cyc(); settle();
        chk("hold_c3_wen", wb_wen, 0);
        cyc(); hold = 1'b0; settle();
        chk("hold_release_wen", wb_wen, 1);
        chk("hold_release_data", wb_data, 2);
        cyc(); settle();
        chk("hold_op3_wen", wb_wen, 1);
        chk("hold_op3_data", wb_data, 3);
        cyc(); settle();
        chk("hold_drained", wb_valid, 0);
        chk("hold_writes", log_rd.size() - n0, 3);
        chk("hold_w0", log_data[n0], 1);
        chk("hold_w1", log_data[n0+1], 2);
        chk("hold_w2", log_data[n0+2], 3);

        // DIV by zero followed by an op reading the DIV's rd
        n0 = log_rd.size(); e0 = exc_cnt;
        cyc(); offer(DIV, 3, 4, 5, 9, 0, 0, 0, 1);
        cyc(); offer(ADD, 5, 2, 6, 10, 2, 0, 0, 1);
        cyc(); idle(); settle();
        chk("div0_exc", exc_valid, 1);
        chk("div0_wen", wb_wen, 0);
        chk("div0_no_fwd", alu_r1, 10);
        cyc(); settle();
        chk("div0_next_exc", exc_valid, 0);
        chk("div0_next_wen", wb_wen, 1);
        chk("div0_next_data", wb_data, 12);
        cyc(); settle();
        chk("div0_exc_count", exc_cnt - e0, 1);
        chk("div0_writes", log_rd.size() - n0, 1);

        // Flush kills E and the offered op, W still writes
        n0 = log_rd.size();
        cyc(); offer(ADD, 1, 2, 9, 1, 1, 0, 0, 1);
        cyc(); offer(ADD, 3, 4, 10, 3, 3, 0, 0, 1);
        cyc(); offer(ADD, 5, 6, 11, 5, 5, 0, 0, 1); flush = 1'b1; settle();
        chk("flush_w_wen", wb_wen, 1);
        chk("flush_w_data", wb_data, 2);
        cyc(); idle(); flush = 1'b0; settle();
        chk("flush_w_empty", wb_valid, 0);
        chk("flush_e_r1", alu_r1, 0);
        cyc(); settle();
        chk("flush_w_empty2", wb_valid, 0);
        cyc(); settle();
        chk("flush_writes", log_rd.size() - n0, 1);
        chk("flush_write_rd", log_rd[n0], 9);

        // Flush together with hold: E dies, W is held then writes once
        n0 = log_rd.size();
        cyc(); offer(ADD, 1, 2, 12, 4, 4, 0, 0, 1);
        cyc(); offer(ADD, 3, 4, 13, 6, 6, 0, 0, 1);
        cyc(); idle(); hold = 1'b1; flush = 1'b1; settle();
        chk("fh_held_wen", wb_wen, 0);
        cyc(); hold = 1'b0; flush = 1'b0; settle();
        chk("fh_wen", wb_wen, 1);
        chk("fh_rd", wb_rd, 12);
        chk("fh_data", wb_data, 8);
        chk("fh_e_r1", alu_r1, 0);
        cyc(); settle();
        chk("fh_drained", wb_valid, 0);
        cyc(); settle();
        chk("fh_writes", log_rd.size() - n0, 1);

        // Write to x0 is suppressed and never forwarded
        n0 = log_rd.size();
        cyc(); offer(ADD, 1, 2, 0, 5, 5, 0, 0, 1);
        cyc(); offer(ADD, 0, 3, 14, 0, 3, 0, 0, 1);
        cyc(); idle(); settle();
        chk("x0_valid", wb_valid, 1);
        chk("x0_wen", wb_wen, 0);
        chk("x0_no_fwd", alu_r1, 0);
        cyc(); settle();
        chk("x0_next_rd", wb_rd, 14);
        chk("x0_next_data", wb_data, 3);
        cyc(); settle();
        chk("x0_writes", log_rd.size() - n0, 1);

        // Reset during hold
        n0 = log_rd.size();
        cyc(); offer(ADD, 1, 2, 15, 1, 1, 0, 0, 1);
        cyc(); offer(ADD, 3, 4, 16, 2, 2, 0, 0, 1);
        cyc(); idle(); hold = 1'b1; settle();
        chk("rh_held_wen", wb_wen, 0);
        cyc(); rst = 1'b1; settle();
        cyc(); rst = 1'b0; hold = 1'b0; settle();
        chk("rh_wb_valid", wb_valid, 0);
        chk("rh_wb_wen", wb_wen, 0);
        chk("rh_wb_rd", wb_rd, 0);
        chk("rh_wb_data", wb_data, 0);
        chk("rh_exc", exc_valid, 0);
        chk("rh_alu_op", alu_op, ADD);
        chk("rh_alu_r1", alu_r1, 0);
        chk("rh_alu_r2", alu_r2, 0);
        cyc(); settle();
        chk("rh_still_empty", wb_valid, 0);
        cyc(); settle();
        chk("rh_writes", log_rd.size() - n0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
